// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//
// Programmable VGA raster timing generator. A horizontal phase machine
// (SYNC -> BACK -> DISP -> FRONT) runs once per line. A vertical phase
// machine with the same phase order advances one line on the last cycle
// of each horizontal front porch.
//
// Timing lengths are written into a shadow register bank through the cfg_*
// port. A commit request copies the whole bank into the active set, either
// at the next frame boundary or, while the generator is idle, on the
// following cycle. Running timing is therefore never disturbed mid-frame.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           run enable, 0 holds the generator idle
//   cfg_we       write cfg_wdata into shadow register cfg_addr
//   cfg_addr     0 H_DISP, 1 H_FRONT, 2 H_SYNC, 3 H_BACK,
//                4 V_DISP, 5 V_FRONT, 6 V_SYNC, 7 V_BACK
//   cfg_wdata    phase length in cycles (H) or lines (V); 0 is stored as 1
//   cfg_commit   request shadow-to-active transfer
//   cfg_pending  commit requested but not yet applied
//   hsync/vsync  sync outputs, equal to SYNC_POL while active
//   de           display enable
//   pix_x/pix_y  pixel coordinate inside the display area, 0 elsewhere
//   line_start   one-cycle pulse on the first cycle of every line
//   frame_start  one-cycle pulse on the first cycle of every frame
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int         H_DISP   = 1280,
  parameter int         H_FRONT  = 48,
  parameter int         H_SYNC   = 112,
  parameter int         H_BACK   = 248,
  parameter int         V_DISP   = 1024,
  parameter int         V_FRONT  = 1,
  parameter int         V_SYNC   = 3,
  parameter int         V_BACK   = 38,
  parameter logic       SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [10:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_pending,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        line_start,
  output logic        frame_start
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_SYNC  = 3'd1,
    PH_BACK  = 3'd2,
    PH_DISP  = 3'd3,
    PH_FRONT = 3'd4
  } phase_e;

  // Register bank layout, index = cfg_addr.
  localparam logic [7:0][10:0] DEFAULTS = {
    11'(V_BACK), 11'(V_SYNC), 11'(V_FRONT), 11'(V_DISP),
    11'(H_BACK), 11'(H_SYNC), 11'(H_FRONT), 11'(H_DISP)
  };

  phase_e            h_state_q, h_state_d;
  phase_e            v_state_q, v_state_d;
  logic [10:0]       h_cnt_q, h_cnt_d;
  logic [10:0]       v_cnt_q, v_cnt_d;
  logic [7:0][10:0]  shadow_q, shadow_d;
  logic [7:0][10:0]  active_q, active_d;
  logic              pending_d;

  logic [10:0]       h_len, v_len;
  logic              h_last, v_last, line_end, frame_end, load;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_SYNC:  next_phase = PH_BACK;
      PH_BACK:  next_phase = PH_DISP;
      PH_DISP:  next_phase = PH_FRONT;
      PH_FRONT: next_phase = PH_SYNC;
      default:  next_phase = PH_IDLE;
    endcase
  endfunction

  function automatic logic [10:0] phase_len(input phase_e ph,
                                            input logic [10:0] l_sync,
                                            input logic [10:0] l_back,
                                            input logic [10:0] l_disp,
                                            input logic [10:0] l_front);
    case (ph)
      PH_SYNC:  phase_len = l_sync;
      PH_BACK:  phase_len = l_back;
      PH_DISP:  phase_len = l_disp;
      PH_FRONT: phase_len = l_front;
      default:  phase_len = 11'd1;
    endcase
  endfunction

  assign h_len = phase_len(h_state_q, active_q[2], active_q[3], active_q[0], active_q[1]);
  assign v_len = phase_len(v_state_q, active_q[6], active_q[7], active_q[4], active_q[5]);

  assign h_last    = (h_cnt_q == h_len - 11'd1);
  assign v_last    = (v_cnt_q == v_len - 11'd1);
  assign line_end  = (h_state_q == PH_FRONT) && h_last;
  assign frame_end = line_end && (v_state_q == PH_FRONT) && v_last;

  // Phase machines: next-state logic
  always_comb begin
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (!en) begin
      h_state_d = PH_IDLE;
      v_state_d = PH_IDLE;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
    end else if (h_state_q == PH_IDLE) begin
      h_state_d = PH_SYNC;
      v_state_d = PH_SYNC;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
    end else if (h_last) begin
      h_cnt_d   = '0;
      h_state_d = next_phase(h_state_q);
      if (line_end) begin
        if (v_last) begin
          v_cnt_d   = '0;
          v_state_d = next_phase(v_state_q);
        end else begin
          v_cnt_d = v_cnt_q + 11'd1;
        end
      end
    end else begin
      h_cnt_d = h_cnt_q + 11'd1;
    end
  end

  // Configuration: the shadow write of this cycle is folded into shadow_d so
  // that a write coinciding with the transfer is part of the committed set.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) begin
      shadow_d[cfg_addr] = (cfg_wdata == 11'd0) ? 11'd1 : cfg_wdata;
    end
    load = ((cfg_pending || cfg_commit) && frame_end) ||
           (cfg_pending && (h_state_q == PH_IDLE));
    active_d  = load ? shadow_d : active_q;
    pending_d = load ? 1'b0 : (cfg_pending || cfg_commit);
  end

  // State, configuration and outputs. Outputs are derived from the next
  // state so that each registered output describes the phase held in the
  // state registers during the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state_q   <= PH_IDLE;
      v_state_q   <= PH_IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      shadow_q    <= DEFAULTS;
      active_q    <= DEFAULTS;
      cfg_pending <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_state_q   <= h_state_d;
      v_state_q   <= v_state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cfg_pending <= pending_d;
      hsync       <= (h_state_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_state_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      de          <= (h_state_d == PH_DISP) && (v_state_d == PH_DISP);
      pix_x       <= (h_state_d == PH_DISP) ? h_cnt_d : 11'd0;
      pix_y       <= (v_state_d == PH_DISP) ? v_cnt_d : 11'd0;
      line_start  <= (h_state_d == PH_SYNC) && (h_cnt_d == 11'd0);
      frame_start <= (h_state_d == PH_SYNC) && (h_cnt_d == 11'd0) &&
                     (v_state_d == PH_SYNC) && (v_cnt_d == 11'd0);
    end
  end

endmodule
